// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the downstream reset. It retries on timeout and on lock loss.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic       timeout_err
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n_int;
  logic [1:0]       r_lock_sync;
  logic             w_lock_s;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_retry_inc;
  logic             w_timeout;

  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic [3:0]       r_retry;
  logic             r_timeout_err;

  // Assertion is immediate; release reaches the core two clki edges later.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n_int = r_rst_sync[1];

  always_ff @(posedge clki or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_lock};
    end
  end

  assign w_lock_s = r_lock_sync[1];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_retry_inc  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_next = S_STABLE;
          w_cnt_next   = '0;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_next = S_RESET_PLL;
          w_cnt_next   = '0;
          w_retry_inc  = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!w_lock_s) begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_cnt_next = '0;
        // Lock loss wins over a coincident relock request: one exit, one increment.
        if (!w_lock_s) begin
          w_state_next = S_RESET_PLL;
          w_retry_inc  = 1'b1;
        end else if (relock_req) begin
          w_state_next = S_RESET_PLL;
        end
      end
      default: begin
        w_state_next = S_RESET_PLL;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clki or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      r_state       <= S_RESET_PLL;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_retry       <= 4'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      // Outputs are decoded from the next state so they change with the state register.
      r_pll_rst <= (w_state_next == S_RESET_PLL);
      r_sys_rst <= (w_state_next != S_RUN);
      r_ready   <= (w_state_next == S_RUN);
      if (w_retry_inc && (r_retry != 4'hF)) begin
        r_retry <= r_retry + 4'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign retry_count = r_retry;
  assign timeout_err = r_timeout_err;

endmodule
